// File: rtl/fp32_to_int32.sv
// IEEE-754 single-precision to signed 32-bit integer converter with saturation,
// invalid/inexact flags and a stb/ack handshake on both sides.
module fp32_to_int32 #(
    parameter bit ROUND_NEAREST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack,
    output logic        output_z_invalid,
    output logic        output_z_inexact
);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        UNPACK  = 3'd1,
        CONVERT = 3'd2,
        ROUND   = 3'd3,
        PUT_Z   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic        spec_q, spec_d;
    logic [31:0] spec_z_q, spec_z_d;
    logic        spec_inv_q, spec_inv_d;
    logic        spec_inx_q, spec_inx_d;
    logic [31:0] mag_q, mag_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic        in_ack_q, in_ack_d;
    logic        z_stb_q, z_stb_d;
    logic [31:0] z_q, z_d;
    logic        inv_q, inv_d;
    logic        inx_q, inx_d;

    logic        s_s;
    logic [7:0]  e_s;
    logic [22:0] m_s;
    logic [4:0]  u_s;
    logic [4:0]  sh_s;
    logic [31:0] full_s;
    logic [31:0] rounded_s;
    logic        inc_s;

    assign s_s    = a_q[31];
    assign e_s    = a_q[30:23];
    assign m_s    = a_q[22:0];
    // Unbiased exponent only matters for e in 127..157, so mod-32 arithmetic suffices.
    assign u_s    = a_q[27:23] - 5'd31;
    assign sh_s   = 5'd23 - u_s;
    assign full_s = {8'd0, 1'b1, m_s};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            GET_A: begin
                if (input_a_stb && in_ack_q) begin
                    state_d = UNPACK;
                end else begin
                    state_d = GET_A;
                end
            end
            UNPACK:  state_d = CONVERT;
            CONVERT: state_d = ROUND;
            ROUND:   state_d = PUT_Z;
            PUT_Z: begin
                if (output_z_ack) begin
                    state_d = GET_A;
                end else begin
                    state_d = PUT_Z;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    // Datapath and handshake output next values
    always_comb begin
        a_d        = a_q;
        spec_d     = spec_q;
        spec_z_d   = spec_z_q;
        spec_inv_d = spec_inv_q;
        spec_inx_d = spec_inx_q;
        mag_d      = mag_q;
        guard_d    = guard_q;
        sticky_d   = sticky_q;
        in_ack_d   = in_ack_q;
        z_stb_d    = z_stb_q;
        z_d        = z_q;
        inv_d      = inv_q;
        inx_d      = inx_q;
        inc_s      = ROUND_NEAREST && guard_q && (sticky_q || mag_q[0]);
        rounded_s  = mag_q + {31'd0, inc_s};
        case (state_q)
            GET_A: begin
                if (input_a_stb && in_ack_q) begin
                    a_d      = input_a;
                    in_ack_d = 1'b0;
                end else begin
                    in_ack_d = 1'b1;
                end
            end
            UNPACK: begin
                spec_d     = 1'b1;
                spec_inv_d = 1'b1;
                spec_inx_d = 1'b0;
                spec_z_d   = 32'h8000_0000;
                if (e_s == 8'd255 && m_s != 23'd0) begin
                    spec_z_d = 32'h8000_0000;
                end else if (e_s == 8'd255 || e_s >= 8'd158) begin
                    spec_z_d = s_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    if (s_s && e_s == 8'd158 && m_s == 23'd0) begin
                        spec_inv_d = 1'b0;
                    end else begin
                        spec_inv_d = 1'b1;
                    end
                end else if (e_s == 8'd0) begin
                    spec_z_d   = 32'd0;
                    spec_inv_d = 1'b0;
                    spec_inx_d = (m_s != 23'd0);
                end else if (e_s < 8'd127) begin
                    spec_inv_d = 1'b0;
                    spec_inx_d = 1'b1;
                    if (ROUND_NEAREST && e_s == 8'd126 && m_s != 23'd0) begin
                        spec_z_d = s_s ? 32'hFFFF_FFFF : 32'd1;
                    end else begin
                        spec_z_d = 32'd0;
                    end
                end else begin
                    spec_d     = 1'b0;
                    spec_inv_d = 1'b0;
                end
            end
            CONVERT: begin
                if (u_s >= 5'd23) begin
                    mag_d    = full_s << (u_s - 5'd23);
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                end else begin
                    mag_d    = full_s >> sh_s;
                    guard_d  = full_s[sh_s - 5'd1];
                    sticky_d = |(full_s & ((32'd1 << (sh_s - 5'd1)) - 32'd1));
                end
            end
            ROUND: begin
                z_stb_d = 1'b1;
                if (spec_q) begin
                    z_d   = spec_z_q;
                    inv_d = spec_inv_q;
                    inx_d = spec_inx_q;
                end else begin
                    z_d   = s_s ? (32'd0 - rounded_s) : rounded_s;
                    inv_d = 1'b0;
                    inx_d = guard_q || sticky_q;
                end
            end
            PUT_Z: begin
                if (output_z_ack) begin
                    z_stb_d  = 1'b0;
                    in_ack_d = 1'b1;
                end else begin
                    z_stb_d  = 1'b1;
                end
            end
            default: begin
                z_stb_d  = 1'b0;
                in_ack_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= 32'd0;
            spec_q     <= 1'b0;
            spec_z_q   <= 32'd0;
            spec_inv_q <= 1'b0;
            spec_inx_q <= 1'b0;
            mag_q      <= 32'd0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            in_ack_q   <= 1'b0;
            z_stb_q    <= 1'b0;
            z_q        <= 32'd0;
            inv_q      <= 1'b0;
            inx_q      <= 1'b0;
        end else begin
            a_q        <= a_d;
            spec_q     <= spec_d;
            spec_z_q   <= spec_z_d;
            spec_inv_q <= spec_inv_d;
            spec_inx_q <= spec_inx_d;
            mag_q      <= mag_d;
            guard_q    <= guard_d;
            sticky_q   <= sticky_d;
            in_ack_q   <= in_ack_d;
            z_stb_q    <= z_stb_d;
            z_q        <= z_d;
            inv_q      <= inv_d;
            inx_q      <= inx_d;
        end
    end

    assign input_a_ack      = in_ack_q;
    assign output_z_stb     = z_stb_q;
    assign output_z         = z_q;
    assign output_z_invalid = inv_q;
    assign output_z_inexact = inx_q;

endmodule

// File: doc/fp32_to_int32.md
Name: fp32_to_int32

Overview:
- Single-precision float to signed 32-bit integer converter.
- Sits directly downstream of the float multiplier and consumes its output_z stream over the same stb/ack handshake.
- Produces a two's-complement integer with saturation, plus invalid and inexact flags, for the integer datapath.
- Multi-cycle FSM; accepts at most one operand in flight.

Parameters:
ROUND_NEAREST, 0, 0 = truncate toward zero (C cast semantics); 1 = round to nearest, ties to even.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
input_a  input  32  IEEE-754 single operand (normally the multiplier's output_z)
input_a_stb  input  1  operand valid
input_a_ack  output  1  operand ready; transfer on an edge where stb && ack
output_z  output  32  signed integer result
output_z_stb  output  1  result valid
output_z_ack  input  1  consumer ready; transfer on an edge where stb && ack
output_z_invalid  output  1  NaN, infinity or out-of-range input; valid with output_z_stb
output_z_inexact  output  1  result differs from the exact input value; valid with output_z_stb

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. On an edge with rst=1:
  - state <= GET_A.
  - input_a_ack, output_z_stb, output_z, output_z_invalid, output_z_inexact all <= 0.
  - Any in-flight operand or result is discarded.
  - rst has priority over every handshake in the same edge.
- States: GET_A -> UNPACK -> CONVERT -> ROUND -> PUT_Z -> GET_A. All handshake outputs are registered.
- GET_A:
  - input_a_ack <= 1 (first edge after reset release sets it).
  - On an edge with input_a_stb && input_a_ack: latch input_a, input_a_ack <= 0, go to UNPACK.
- UNPACK: split into sign s, exponent e[7:0], mantissa m[22:0]; classify the operand.
- CONVERT: u = e - 127; mag = {1,m}.
  - u in 23..30: mag << (u-23), exact.
  - u in 0..22: mag >> (23-u); keep guard = first dropped bit, sticky = OR of the remaining dropped bits.
- ROUND:
  - If ROUND_NEAREST=1: increment when guard && (sticky || lsb).
  - Negate if s=1.
  - Register output_z and flags; output_z_stb <= 1; go to PUT_Z.
- PUT_Z:
  - output_z, flags and stb are held stable while output_z_ack=0.
  - On an edge with output_z_ack=1: output_z_stb <= 0, input_a_ack <= 1, go to GET_A.
  - output_z keeps its last value after the handshake.
- Latency and throughput:
  - output_z_stb is visible 3 cycles after the accept edge (accept edge E, stb high after E+3).
  - With ack held high, minimum period is one operand per 5 cycles.
- Special cases (checked in priority order):
  - e=255, m!=0 (NaN): 32'h8000_0000, invalid=1, inexact=0.
  - e=255, m=0 (infinity): +inf gives 32'h7FFF_FFFF, -inf gives 32'h8000_0000; invalid=1.
  - e>=158: 32'h8000_0000 with no flags if s=1, e=158 and m=0 (exactly -2^31). Otherwise saturate by sign (7FFF_FFFF / 8000_0000) with invalid=1.
  - e=0 (zero or denormal): result 0; inexact = (m!=0); -0 gives 0.
  - 0<e<127 (|x|<1):
    - Truncate mode: result 0, inexact=1.
    - Nearest mode: result ±1 only if e=126 and m!=0 (above 0.5); exactly 0.5 gives 0. inexact=1.
  - Normal range: inexact = guard || sticky. Rounding cannot overflow, because u<=22 gives a magnitude of at most 2^23.
- The operand width is 32 throughout; mag uses a 32-bit unsigned datapath before negation.

Test Plan:
- Truncate mode, 0x40490FDB (3.14159) -> output_z=3, inexact=1, invalid=0. Also check 0xC0200000 (-2.5) -> 32'hFFFF_FFFE, inexact=1.
- ROUND_NEAREST=1:
  - 0x3FC00000 (1.5) -> 2.
  - 0x40200000 (2.5) -> 2.
  - 0xC0200000 (-2.5) -> 32'hFFFF_FFFE.
  - 0x3F400000 (0.75) -> 1.
  - 0x3F000000 (0.5) -> 0.
  - All with inexact=1.
- Saturation and specials:
  - 0x4F000000 -> 7FFF_FFFF, invalid=1.
  - 0xCF000000 -> 8000_0000, no flags.
  - 0x7FC00000 -> 8000_0000, invalid=1.
  - 0xFF800000 -> 8000_0000, invalid=1.
  - 0x80000000 -> 0, no flags.
  - 0x00000001 -> 0, inexact=1.
- Handshake timing:
  - Accept 0x4B000001 (8388609) at edge E -> stb high after E+3, output_z=8388609, exact.
  - Hold output_z_ack=0 for 10 cycles -> stb, data and flags stable, input_a_ack=0.
  - Raise ack -> stb drops and input_a_ack rises on the same edge.
- Back-to-back: stream 1.0, 2.0, 3.0 with stb and ack always high -> results 1, 2, 3 in order, exactly 5 cycles apart.
- Reset mid-op: assert rst for 1 cycle while in CONVERT -> stb never rises for that operand, all outputs 0; input_a_ack=1 one edge after rst release; next operand 0x41200000 (10.0) -> 10.
